pair_lane_tx: RTL and testbench
===============================

PAIR_LANE_TX -- requirements
Module: pair_lane_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the request word width; legal values are even and 2..64.
REQ-002 The block SHALL have parameter RESP_LAT, default 1, giving the cycles from a lane beat to its z response; legal values are 0..3.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  the reset, synchronous and active-low.
REQ-005 The block SHALL have port s_valid  input  1  request word valid.
REQ-006 The block SHALL have port s_ready  output  1  block ready to accept a request word.
REQ-007 The block SHALL have port s_data  input  WIDTH  request word.
REQ-008 The block SHALL have port out1  output  1  lane-1 bit of the current beat.
REQ-009 The block SHALL have port out2  output  1  lane-2 bit of the current beat.
REQ-010 The block SHALL have port out_valid  output  1  a lane beat is being driven this cycle.
REQ-011 The block SHALL have port z  input  1  response bit from the downstream two-input responder.
REQ-012 The block SHALL have port r_valid  output  1  one-cycle pulse marking that r_data is valid.
REQ-013 The block SHALL have port r_data  output  WIDTH/2  collected response bits.
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, SHIFT and DRAIN.
REQ-016 s_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when s_valid and s_ready are both 1; on acceptance the block SHALL capture s_data and enter SHIFT on the next cycle.
REQ-018 s_valid SHALL be ignored outside IDLE, with no queuing.
REQ-019 In SHIFT, beat k SHALL run for k = 0..WIDTH/2-1, one beat per cycle, with no gaps.
REQ-020 During beat k, out1 SHALL equal s_data[2k], out2 SHALL equal s_data[2k+1], and out_valid SHALL be 1.
REQ-021 When out_valid is 0, out1 and out2 SHALL be 0.
REQ-022 The z response to beat k SHALL be sampled exactly RESP_LAT cycles after beat k and stored into r_data[k], LSB-first.
REQ-023 If RESP_LAT = 0, z SHALL be sampled in the same cycle as its beat.
REQ-024 After the last beat, the block SHALL enter DRAIN for RESP_LAT cycles; if RESP_LAT = 0, DRAIN SHALL be skipped.
REQ-025 r_valid SHALL pulse for exactly 1 cycle, in the cycle after the last z sample, and the block SHALL be in IDLE with s_ready = 1 in that same cycle.
REQ-026 End-to-end latency SHALL be: request accepted at cycle T gives r_valid at cycle T + WIDTH/2 + RESP_LAT + 1.
REQ-027 r_data SHALL hold its value until the next r_valid or reset.
REQ-028 A new request SHALL be acceptable in the r_valid cycle, so back-to-back words run with one idle cycle between beat trains.
REQ-029 z SHALL be ignored in every cycle except the sample cycles defined in REQ-022.
REQ-030 For WIDTH = 2, SHIFT SHALL last exactly 1 cycle.

Reset
REQ-031 While rst_n = 0 at a clock edge, the block SHALL go to IDLE, and s_ready, out1, out2, out_valid, r_valid, busy and r_data SHALL all be 0.
REQ-032 s_ready SHALL read 0 while reset is held and SHALL become 1 on the first edge with rst_n = 1.
REQ-033 Reset asserted during SHIFT or DRAIN SHALL abandon the word: no further beats and no r_valid for that word.
REQ-034 After a reset taken mid-operation, the next accepted word SHALL behave exactly as it would after a cold reset.

Verification
REQ-035 Scenario: WIDTH = 8, RESP_LAT = 1; accept s_data = 8'hB4 at cycle 0; z echoes (out1 XOR out2) delayed 1 cycle -> beats at cycles 1..4 carry (out1,out2) = (0,0), (1,0), (1,1), (0,1); r_valid at cycle 6 with r_data = 4'b1010.
REQ-036 Scenario: WIDTH = 8, RESP_LAT = 0; accept at cycle 0; z tied to 1 -> beats at cycles 1..4, DRAIN skipped, r_valid at cycle 5 with r_data = 4'hF.
REQ-037 Scenario: hold s_valid = 1 continuously from cycle 0 -> words accepted only in IDLE cycles (cycles 0, 6, 12 for WIDTH = 8, RESP_LAT = 1); s_ready = 0 throughout SHIFT and DRAIN; no word duplicated.
REQ-038 Scenario: rst_n = 0 at beat 2 -> out_valid = 0 from the next edge, no r_valid for that word, s_ready = 1 one edge after rst_n returns to 1.
REQ-039 Scenario: WIDTH = 2, RESP_LAT = 3; accept s_data = 2'b10; z = 1 only in cycle 4 -> exactly one beat at cycle 1 with (out1,out2) = (0,1); r_valid at cycle 5 with r_data = 1'b1.
REQ-040 Scenario: toggle z in non-sample cycles during any of the above runs -> r_data unchanged from the expected value.

Source files
------------

// File: rtl/pair_lane_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pair_lane_tx
//  Purpose  : Serialises a request word two bits per beat onto a pair of
//             lanes, collects one response bit per beat from a downstream
//             two-input responder after a fixed latency, and returns the
//             collected bits as a single result word.
//  Revision : 1.0  initial release
// ============================================================================
module pair_lane_tx #(
    parameter int WIDTH    = 8,
    parameter int RESP_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               out1,
    output logic               out2,
    output logic               out_valid,
    input  logic               z,
    output logic               r_valid,
    output logic [WIDTH/2-1:0] r_data,
    output logic               busy
);

    localparam int c_beats = WIDTH / 2;
    localparam int c_cw    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_beats - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cw-1:0]    r_bcnt;
    logic [c_cw-1:0]    r_scnt;
    logic [c_beats-1:0] r_acc;
    logic [c_beats-1:0] w_acc_nxt;
    logic               r_ready;
    logic               w_accept;
    logic               w_sample;
    logic               w_last_beat;
    logic               w_last_sample;

    // s_ready is registered so it stays low while reset is held.
    assign s_ready       = r_ready;
    assign w_accept      = s_valid & r_ready;
    assign busy          = (r_state != ST_IDLE);
    assign out_valid     = (r_state == ST_SHIFT);
    assign out1          = out_valid & r_shift[0];
    assign out2          = out_valid & r_shift[1];
    assign w_last_beat   = (r_bcnt == c_last);
    assign w_last_sample = w_sample & (r_scnt == c_last);

    generate
        if (RESP_LAT == 0) begin : g_lat0
            assign w_sample = out_valid;
        end else begin : g_latn
            logic [RESP_LAT-1:0] r_vpipe;

            // Delay line marking which cycles carry a due response.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= (r_vpipe << 1) | RESP_LAT'(out_valid);
                end
            end

            assign w_sample = r_vpipe[RESP_LAT-1];
        end
    endgenerate

    // Merge the current response bit into its slot of the accumulator.
    always_comb begin
        w_acc_nxt         = r_acc;
        w_acc_nxt[r_scnt] = z;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN ends with the final response sample.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_beat) begin
                    w_state_nxt = (RESP_LAT == 0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_sample) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: word capture, lane shifting, response collection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_scnt  <= '0;
            r_acc   <= '0;
            r_data  <= '0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_valid <= w_last_sample;
            if (w_accept) begin
                r_shift <= s_data;
                r_bcnt  <= '0;
            end else if (out_valid) begin
                r_shift <= r_shift >> 2;
                r_bcnt  <= r_bcnt + 1'b1;
            end
            if (w_accept) begin
                r_scnt <= '0;
            end else if (w_sample) begin
                r_acc  <= w_acc_nxt;
                r_scnt <= r_scnt + 1'b1;
            end
            if (w_last_sample) begin
                r_data <= w_acc_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pair_lane_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pair_lane_tx
//  Purpose  : Self-checking bench for pair_lane_tx. Three instances cover
//             WIDTH/RESP_LAT = 8/1, 8/0 and 2/3. A cycle-level model
//             schedules expected beats, response sample cycles and results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pair_lane_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] sv;
    logic [2:0] sr;
    logic [7:0] sd [3];
    logic [2:0] o1;
    logic [2:0] o2;
    logic [2:0] ov;
    logic [2:0] zz;
    logic [2:0] rv;
    logic [2:0] bz;
    logic [3:0] rd0;
    logic [3:0] rd1;
    logic       rd2;

    pair_lane_tx #(.WIDTH(8), .RESP_LAT(1)) u_w8l1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .out1(o1[0]), .out2(o2[0]), .out_valid(ov[0]), .z(zz[0]),
        .r_valid(rv[0]), .r_data(rd0), .busy(bz[0]));

    pair_lane_tx #(.WIDTH(8), .RESP_LAT(0)) u_w8l0 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .out1(o1[1]), .out2(o2[1]), .out_valid(ov[1]), .z(zz[1]),
        .r_valid(rv[1]), .r_data(rd1), .busy(bz[1]));

    pair_lane_tx #(.WIDTH(2), .RESP_LAT(3)) u_w2l3 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2][1:0]),
        .out1(o1[2]), .out2(o2[2]), .out_valid(ov[2]), .z(zz[2]),
        .r_valid(rv[2]), .r_data(rd2), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         cyc;
        logic [3:0] data;
    } exp_t;

    typedef struct {
        int         d;
        logic [7:0] data;
        int         zm;
        logic [3:0] exp;
    } vec_t;

    exp_t       sbq[$];
    logic [1:0] bmap [int];
    bit         zmap [int];
    int         free_c [3];
    int         busy_from [3];
    logic [3:0] exp_rd [3];
    int         cur_zm [3];
    logic [3:0] pend_exp [3];
    bit         pend_tab [3];
    int         cyc;
    int         checks;
    int         failures;
    vec_t       tbl [9];

    function automatic int nb(int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic bit zbit(int zm, logic a, logic b);
        if (zm == 0) return a ^ b;
        if (zm == 1) return 1'b1;
        return b;
    endfunction

    function automatic logic [3:0] ref_resp(int d, logic [7:0] data, int zm);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < nb(d); k++) r[k] = zbit(zm, data[2*k], data[2*k+1]);
        return r;
    endfunction

    function automatic logic [3:0] get_rd(int d);
        if (d == 0) return rd0;
        if (d == 1) return rd1;
        return {3'b000, rd2};
    endfunction

    task automatic chk(string name, int d, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic schedule(int d, logic [7:0] data);
        int   n;
        int   l;
        exp_t e;
        n = nb(d);
        l = lat(d);
        for (int k = 0; k < n; k++) begin
            bmap[(cyc + 1 + k) * 4 + d]     = {data[2*k+1], data[2*k]};
            zmap[(cyc + 1 + k + l) * 4 + d] = zbit(cur_zm[d], data[2*k], data[2*k+1]);
        end
        e.d    = d;
        e.cyc  = cyc + n + l + 1;
        e.data = pend_tab[d] ? pend_exp[d] : ref_resp(d, data, cur_zm[d]);
        sbq.push_back(e);
        free_c[d]    = cyc + n + l + 1;
        busy_from[d] = cyc + 1;
    endtask

    // Model update for the edge that closes the current cycle.
    task automatic model_edge();
        if (!rst_n) begin
            sbq.delete();
            bmap.delete();
            zmap.delete();
            for (int d = 0; d < 3; d++) begin
                free_c[d]    = cyc + 2;
                busy_from[d] = cyc + 2;
                exp_rd[d]    = '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (sv[d] && cyc >= free_c[d]) schedule(d, sd[d]);
            end
        end
    endtask

    task automatic monitor();
        bit         exp_rv;
        int         key;
        logic [2:0] eb;
        for (int d = 0; d < 3; d++) begin
            exp_rv = 1'b0;
            if (sbq.size() > 0 && sbq[0].d == d && sbq[0].cyc == cyc) begin
                exp_rv    = 1'b1;
                exp_rd[d] = sbq[0].data;
                void'(sbq.pop_front());
            end
            chk("r_valid", d, {7'd0, rv[d]}, {7'd0, exp_rv});
            chk("r_data", d, {4'd0, get_rd(d)}, {4'd0, exp_rd[d]});
            key = cyc * 4 + d;
            eb  = bmap.exists(key) ? {1'b1, bmap[key]} : 3'b000;
            chk("beat{ov,o2,o1}", d, {5'd0, ov[d], o2[d], o1[d]}, {5'd0, eb});
            chk("s_ready", d, {7'd0, sr[d]}, {7'd0, (cyc >= free_c[d])});
            chk("busy", d, {7'd0, bz[d]}, {7'd0, (cyc >= busy_from[d] && cyc < free_c[d])});
        end
    endtask

    // z carries the scheduled response in sample cycles and noise otherwise.
    task automatic drive_z();
        for (int d = 0; d < 3; d++) begin
            if (zmap.exists(cyc * 4 + d)) zz[d] = zmap[cyc * 4 + d];
            else zz[d] = ($urandom_range(0, 1) != 0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
        drive_z();
    endtask

    task automatic wait_ready(int d);
        int guard;
        guard = 0;
        while (cyc < free_c[d] && guard < 60) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_done(int d);
        int guard;
        guard = 0;
        while (sbq.size() > 0 && guard < 60) begin
            tick();
            guard++;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL completion_timeout dut%0d cycle %0d: pending %0d expected 0", d, cyc, sbq.size());
        end
    endtask

    task automatic issue(int d, logic [7:0] data, int zm, logic [3:0] exp);
        wait_ready(d);
        cur_zm[d]   = zm;
        pend_exp[d] = exp;
        pend_tab[d] = 1'b1;
        sv[d]       = 1'b1;
        sd[d]       = data;
        tick();
        sv[d] = 1'b0;
    endtask

    // Accept a word, then hold reset for one cycle after `after` further cycles.
    task automatic abort_word(int d, logic [7:0] data, int after);
        issue(d, data, 0, 4'h0);
        for (int i = 0; i < after; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: simulation time limit reached", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 8'hB4, 0, 4'b1010};
        tbl[1] = '{1, 8'h3C, 1, 4'b1111};
        tbl[2] = '{2, 8'h02, 1, 4'b0001};
        tbl[3] = '{0, 8'hFF, 0, 4'b0000};
        tbl[4] = '{0, 8'h5A, 2, 4'b0011};
        tbl[5] = '{1, 8'h1E, 0, 4'b0101};
        tbl[6] = '{1, 8'hC3, 2, 4'b1001};
        tbl[7] = '{2, 8'h01, 2, 4'b0000};
        tbl[8] = '{2, 8'h03, 0, 4'b0000};

        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        sv       = '0;
        zz       = '0;
        for (int d = 0; d < 3; d++) begin
            sd[d]        = '0;
            free_c[d]    = 2;
            busy_from[d] = 2;
            exp_rd[d]    = '0;
            cur_zm[d]    = 0;
            pend_exp[d]  = '0;
            pend_tab[d]  = 1'b0;
        end

        // Cold reset held for three edges.
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven single words.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].d, tbl[i].data, tbl[i].zm, tbl[i].exp);
            wait_done(tbl[i].d);
        end

        // s_valid held high: acceptance only in IDLE cycles, back-to-back trains.
        wait_ready(0);
        cur_zm[0]   = 0;
        pend_tab[0] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            sv[0] = 1'b1;
            sd[0] = 8'($urandom);
            tick();
        end
        sv[0] = 1'b0;
        wait_done(0);

        // Same on the zero-latency instance.
        wait_ready(1);
        cur_zm[1]   = 0;
        pend_tab[1] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            sv[1] = 1'b1;
            sd[1] = 8'($urandom);
            tick();
        end
        sv[1] = 1'b0;
        wait_done(1);

        // Reset during beat 2, then a word that must behave as after cold reset.
        abort_word(0, 8'hB4, 2);
        issue(0, 8'hB4, 0, 4'b1010);
        wait_done(0);

        // Reset during DRAIN of the long-latency instance, then a fresh word.
        abort_word(2, 8'h02, 1);
        issue(2, 8'h02, 1, 4'b0001);
        wait_done(2);

        // Reset during the last beat of the zero-latency instance.
        abort_word(1, 8'h3C, 3);
        issue(1, 8'h1E, 0, 4'b0101);
        wait_done(1);

        chk("scoreboard_empty", 0, 8'(sbq.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
